// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one external single-cycle ALU between NUM_REQ requesters.
// Optional ALU_RR_ARBITER_OPCHK_EN adds rsp_err and answers illegal opcodes (>100) without using the ALU.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_srca,
  input  logic [32*NUM_REQ-1:0]  req_srcb,
  input  logic [3*NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_result,
  output logic                   rsp_zero,
`ifdef ALU_RR_ARBITER_OPCHK_EN
  output logic                   rsp_err,
`endif
  output logic [31:0]            alu_srca,
  output logic [31:0]            alu_srcb,
  output logic [2:0]             alu_ctrl,
  input  logic [31:0]            alu_result,
  input  logic                   alu_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, grant_q, grant_d, win;
  logic [PTR_W:0] sum;
  logic [NUM_REQ-1:0] win_oh, gnt_oh;
  logic [31:0] srca_q, srca_d, srcb_q, srcb_d, res_q, res_d, win_a, win_b;
  logic [2:0] op_q, op_d, win_op;
  logic zero_q, zero_d, found, illegal, take;
`ifdef ALU_RR_ARBITER_OPCHK_EN
  logic err_q, err_d;
  assign illegal = win_op > 3'b100;
  assign rsp_err = err_q;
`else
  assign illegal = 1'b0;
`endif
  // Search ptr, ptr+1, ... modulo NUM_REQ for the first valid requester.
  always_comb begin
    found = 1'b0;
    win = '0;
    sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      sum = (sum >= (PTR_W+1)'(NUM_REQ)) ? sum - (PTR_W+1)'(NUM_REQ) : sum;
      for (int i = 0; i < NUM_REQ; i++)
        if (!found && req_valid[i] && sum[PTR_W-1:0] == PTR_W'(i)) begin
          found = 1'b1;
          win = PTR_W'(i);
        end
    end
  end
  always_comb begin
    win_a = '0;
    win_b = '0;
    win_op = '0;
    win_oh = '0;
    gnt_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh[i] = found && win == PTR_W'(i);
      gnt_oh[i] = grant_q == PTR_W'(i);
      win_a = win_oh[i] ? req_srca[32*i +: 32] : win_a;
      win_b = win_oh[i] ? req_srcb[32*i +: 32] : win_b;
      win_op = win_oh[i] ? req_op[3*i +: 3] : win_op;
    end
  end
  assign take = |(rsp_ready & gnt_oh);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    srca_d = srca_q;
    srcb_d = srcb_q;
    op_d = op_q;
    res_d = res_q;
    zero_d = zero_q;
`ifdef ALU_RR_ARBITER_OPCHK_EN
    err_d = err_q;
`endif
    case (state_q)
      IDLE: if (found) begin
        grant_d = win;
        state_d = illegal ? RESP : EXEC;
        srca_d = illegal ? srca_q : win_a;
        srcb_d = illegal ? srcb_q : win_b;
        op_d = illegal ? op_q : win_op;
        res_d = illegal ? '0 : res_q;
        zero_d = illegal ? 1'b0 : zero_q;
`ifdef ALU_RR_ARBITER_OPCHK_EN
        err_d = illegal;
`endif
      end
      EXEC: begin
        state_d = RESP;
        res_d = alu_result;
        zero_d = alu_zero;
`ifdef ALU_RR_ARBITER_OPCHK_EN
        err_d = 1'b0;
`endif
      end
      default: if (take) begin
        state_d = IDLE;
        ptr_d = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_q <= '0;
      srca_q <= '0;
      srcb_q <= '0;
      op_q <= '0;
      res_q <= '0;
      zero_q <= 1'b0;
`ifdef ALU_RR_ARBITER_OPCHK_EN
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      srca_q <= srca_d;
      srcb_q <= srcb_d;
      op_q <= op_d;
      res_q <= res_d;
      zero_q <= zero_d;
`ifdef ALU_RR_ARBITER_OPCHK_EN
      err_q <= err_d;
`endif
    end
  end
  assign req_ready = (rst_n && state_q == IDLE) ? win_oh : '0;
  assign rsp_valid = (state_q == RESP) ? gnt_oh : '0;
  assign rsp_result = res_q;
  assign rsp_zero = zero_q;
  assign alu_srca = srca_q;
  assign alu_srcb = srcb_q;
  assign alu_ctrl = op_q;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed bench for alu_rr_arbiter with a transaction-level reference model and external ALU.
module tb_alu_rr_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [63:0] req_srca = '0, req_srcb = '0;
  logic [5:0] req_op = '0;
  logic [31:0] rsp_result, alu_srca, alu_srcb, alu_result;
  logic [2:0] alu_ctrl;
  logic rsp_zero, alu_zero;
  int n_cmp = 0, n_bad = 0;
  int ph, mptr, mgnt;
  logic [31:0] ma, mb, mres;
  logic [2:0] mop;
  logic mz;
  int grants[$];
  int exp_g[8] = '{0, 1, 0, 1, 0, 1, 0, 1};

  always #5 clk = ~clk;

  alu_rr_arbiter #(.NUM_REQ(2), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_srca(req_srca), .req_srcb(req_srcb), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (op == 3'd0) return a + b;
    if (op == 3'd1) return a - b;
    if (op == 3'd2) return a & b;
    if (op == 3'd3) return a | b;
    if (op == 3'd4) return (a < b) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  assign alu_result = alu_fn(alu_srca, alu_srcb, alu_ctrl);
  assign alu_zero = alu_result == 32'd0;

  function automatic int pick(input int p, input logic [1:0] v);
    for (int k = 0; k < 2; k++)
      if (((v >> ((p + k) % 2)) & 2'b01) != 2'b00) return (p + k) % 2;
    return -1;
  endfunction

  function automatic logic [1:0] rdy_exp(input int phase, input logic rn, input int p, input logic [1:0] v);
    int w;
    w = pick(p, v);
    return (phase == 0 && rn && w >= 0) ? 2'(1 << w) : 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: phase 0 waiting, 1 operation in the ALU, 2 response offered.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 0; mptr <= 0; mgnt <= 0; ma <= '0; mb <= '0; mop <= '0; mres <= '0; mz <= 1'b0;
    end else if (ph == 0) begin
      if (pick(mptr, req_valid) >= 0) begin
        mgnt <= pick(mptr, req_valid);
        ma <= req_srca[32*pick(mptr, req_valid) +: 32];
        mb <= req_srcb[32*pick(mptr, req_valid) +: 32];
        mop <= req_op[3*pick(mptr, req_valid) +: 3];
        ph <= 1;
      end
    end else if (ph == 1) begin
      mres <= alu_fn(ma, mb, mop);
      mz <= alu_fn(ma, mb, mop) == 32'd0;
      ph <= 2;
    end else if (((rsp_ready >> mgnt) & 2'b01) != 2'b00) begin
      mptr <= (mgnt + 1) % 2;
      ph <= 0;
    end
  end

  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(rdy_exp(ph, rst_n, mptr, req_valid)));
    chk("rsp_valid", 32'(rsp_valid), (ph == 2) ? 32'(1 << mgnt) : 32'd0);
    chk("rsp_result", rsp_result, mres);
    chk("rsp_zero", 32'(rsp_zero), 32'(mz));
    chk("alu_srca", alu_srca, ma);
    chk("alu_srcb", alu_srcb, mb);
    chk("alu_ctrl", 32'(alu_ctrl), 32'(mop));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_valid[i] = v;
    req_srca[32*i +: 32] = a;
    req_srcb[32*i +: 32] = b;
    req_op[3*i +: 3] = op;
  endtask

  initial begin
    int cnt0, cnt1;
    logic [1:0] g;
    repeat (2) cyc();
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_alu_ctrl", 32'(alu_ctrl), 32'h0);
    rst_n = 1'b1;
    // single SUB from requester 0
    set_req(0, 1'b1, 32'd5, 32'd3, 3'd1);
    #1 chk("t1_ready_c0", 32'(req_ready), 32'h1);
    cyc();
    set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
    #1 chk("t1_alu_a", alu_srca, 32'd5);
    chk("t1_valid_c1", 32'(rsp_valid), 32'h0);
    cyc();
    chk("t1_valid_c2", 32'(rsp_valid), 32'h1);
    chk("t1_result", rsp_result, 32'd2);
    chk("t1_zero", 32'(rsp_zero), 32'h0);
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = 2'b00;
    // wrap-around ADD from requester 1
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'd0);
    #1 chk("t2_ready", 32'(req_ready), 32'h2);
    cyc();
    set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
    cyc();
    chk("t2_valid", 32'(rsp_valid), 32'h2);
    chk("t2_result", rsp_result, 32'h0);
    chk("t2_zero", 32'(rsp_zero), 32'h1);
    rsp_ready = 2'b10;
    cyc();
    rsp_ready = 2'b00;
    // both requesters continuously valid, four ops each
    rsp_ready = 2'b11;
    cnt0 = 0;
    cnt1 = 0;
    set_req(0, 1'b1, 32'd0, 32'd1, 3'd0);
    set_req(1, 1'b1, 32'd1000, 32'd1, 3'd2);
    for (int t = 0; t < 60 && (cnt0 < 4 || cnt1 < 4); t++) begin
      #1 g = req_ready;
      cyc();
      if (g[0]) begin
        cnt0++;
        set_req(0, cnt0 < 4, 32'(37 * cnt0), 32'(5 * cnt0 + 1), 3'(cnt0 % 5));
      end
      if (g[1]) begin
        cnt1++;
        set_req(1, cnt1 < 4, 32'(1000 + 37 * cnt1), 32'(5 * cnt1 + 1), 3'((cnt1 + 2) % 5));
      end
      if (g != 2'b00) grants.push_back(g[1] ? 1 : 0);
    end
    chk("t3_grant_count", 32'(grants.size()), 32'd8);
    for (int k = 0; k < grants.size() && k < 8; k++) chk("t3_grant_order", 32'(grants[k]), 32'(exp_g[k]));
    repeat (3) cyc();
    rsp_ready = 2'b00;
    // response stalled five cycles
    set_req(0, 1'b1, 32'h10, 32'h20, 3'd4);
    cyc();
    set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
    set_req(1, 1'b1, 32'hF0F0, 32'hFF00, 3'd2);
    #1 chk("t4_ready_exec", 32'(req_ready), 32'h0);
    cyc();
    for (int s = 0; s < 5; s++) begin
      #1 chk("t4_stall_valid", 32'(rsp_valid), 32'h1);
      chk("t4_stall_result", rsp_result, 32'd1);
      chk("t4_stall_ready", 32'(req_ready), 32'h0);
      cyc();
    end
    rsp_ready = 2'b01;
    cyc();
    #1 chk("t4_idle_valid", 32'(rsp_valid), 32'h0);
    chk("t4_idle_ready", 32'(req_ready), 32'h2);
    rsp_ready = 2'b00;
    cyc();
    set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
    cyc();
    chk("t4_and_result", rsp_result, 32'hF000);
    rsp_ready = 2'b10;
    cyc();
    rsp_ready = 2'b00;
    // reset asserted during EXEC
    set_req(0, 1'b1, 32'd3, 32'd4, 3'd3);
    cyc();
    set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
    #1 chk("t5_exec_alu_a", alu_srca, 32'd3);
    rst_n = 1'b0;
    #1 chk("t5_rst_alu_a", alu_srca, 32'd0);
    chk("t5_rst_alu_ctrl", 32'(alu_ctrl), 32'h0);
    chk("t5_rst_result", rsp_result, 32'd0);
    chk("t5_rst_valid", 32'(rsp_valid), 32'h0);
    repeat (2) cyc();
    rst_n = 1'b1;
    set_req(1, 1'b1, 32'd40, 32'd2, 3'd0);
    #1 chk("t5_post_ready", 32'(req_ready), 32'h2);
    cyc();
    set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
    cyc();
    chk("t5_post_result", rsp_result, 32'd42);
    rsp_ready = 2'b10;
    cyc();
    rsp_ready = 2'b00;
    // unused opcode passes through to the ALU
    set_req(0, 1'b1, 32'd7, 32'd9, 3'd7);
    cyc();
    set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
    cyc();
    chk("t6_result", rsp_result, 32'd0);
    chk("t6_zero", 32'(rsp_zero), 32'h1);
    chk("t6_alu_ctrl", 32'(alu_ctrl), 32'h7);
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = 2'b00;
    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares the single-cycle integer ALU between NUM_REQ requesters, e.g. the core pipeline and a debug/CSR unit.
- Round-robin arbitration; one operation in flight at a time.
- Operands and opcode are registered before the ALU. The result is registered after it.
- Results return through a per-requester valid/ready response handshake.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- PTR_W, 2, width of the round-robin pointer and grant index; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  bit i: requester i presents an operation.
- req_ready  out  NUM_REQ  bit i: operation from requester i is accepted this cycle.
- req_srca  in  32*NUM_REQ  operand A; requester i at bits [32i+31:32i].
- req_srcb  in  32*NUM_REQ  operand B; same packing as req_srca.
- req_op  in  3*NUM_REQ  ALU opcode; requester i at bits [3i+2:3i].
- rsp_valid  out  NUM_REQ  bit i: result for requester i is available.
- rsp_ready  in  NUM_REQ  bit i: requester i takes the result.
- rsp_result  out  32  result of the granted operation.
- rsp_zero  out  1  zero flag of the granted operation.
- alu_srca  out  32  operand A to the ALU.
- alu_srcb  out  32  operand B to the ALU.
- alu_ctrl  out  3  opcode to the ALU: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (unsigned compare).
- alu_result  in  32  result from the ALU.
- alu_zero  in  1  zero flag from the ALU.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, ptr=0, grant=0.
  - req_ready=0, rsp_valid=0.
  - rsp_result=0, rsp_zero=0.
  - alu_srca=0, alu_srcb=0, alu_ctrl=000.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On the edge: latch the winner's srca/srcb/op into the operand registers, grant=winner, go to EXEC.
  - If no req_valid bit is set, stay in IDLE with all req_ready=0.
- EXEC:
  - alu_srca/alu_srcb/alu_ctrl are driven from the operand registers.
  - On the edge: rsp_result<=alu_result, rsp_zero<=alu_zero, go to RESP.
- RESP:
  - rsp_valid[grant]=1; all other rsp_valid bits are 0.
  - rsp_result and rsp_zero are held stable until the transfer.
  - When rsp_ready[grant]=1: ptr<=(grant+1) mod NUM_REQ, go to IDLE.
  - A stalled requester (rsp_ready=0) holds the arbiter in RESP indefinitely.
- req_ready is 0 in EXEC and RESP. A requester must hold req_valid and its operands stable until req_ready.
- ALU inputs hold their last value outside EXEC. No combinational path exists from req_* to alu_*.
- Latency: accept at edge N, result captured at edge N+1, rsp_valid high during cycle N+1..N+2. Peak throughput is one operation per 3 cycles.
- Fairness:
  - ptr advances only on response transfer.
  - With all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
  - A requester waits at most NUM_REQ-1 operations before its grant.
- ptr wrap: NUM_REQ-1 wraps to 0.
- Deasserting req_valid before req_ready is legal. The request is simply not taken.
- Reset mid-operation: an in-flight operation is discarded with no response. Requesters must reissue.
- Unused opcodes 101..111 are passed to the ALU unchanged; the ALU returns 0 and zero=1.

Optional Feature:
- Macro: ALU_RR_ARBITER_OPCHK_EN.
- When defined:
  - An output port rsp_err (1 bit) is added.
  - An accepted opcode >100 skips EXEC: IDLE goes directly to RESP with rsp_result=0, rsp_zero=0, rsp_err=1.
  - rsp_err=0 for legal opcodes; reset value 0.
  - The ALU inputs are not updated for illegal ops.
- When undefined: no rsp_err port; all opcodes go through EXEC as described above.

Test Plan:
- Single op, req 0: srca=5, srcb=3, op=001 -> req_ready[0] in cycle 0; rsp_valid[0] from cycle 2; rsp_result=2, rsp_zero=0.
- Requester 1 issues op=000, srca=0xFFFFFFFF, srcb=1 -> rsp_result=0, rsp_zero=1 (wrap-around).
- Both requesters valid continuously, 4 ops each -> grants 0,1,0,1,...; all responses carry the correct requester's results.
- rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_result stable, req_ready=0 throughout; IDLE one cycle after rsp_ready rises.
- rst_n asserted during EXEC -> all outputs reset immediately, no response; after release, requester 1 valid is granted first only if ptr=0 and req 0 is idle.
- With ALU_RR_ARBITER_OPCHK_EN: op=111 -> rsp_valid one cycle after accept, rsp_err=1, rsp_result=0; alu_ctrl unchanged.
